// File: rtl/image_pkg.sv
// ============================================================================
//  Package   : image_pkg
//  Purpose   : Shared image sizing defaults, loader states, pixel type and
//              RAM-router command encodings.
//  Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package image_pkg;

  localparam int IMAGE_PIXELS_DEFAULT   = 65536;
  localparam int ADDR_WIDTH_DEFAULT     = 16;
  localparam int TIMEOUT_CYCLES_DEFAULT = 1000000;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } loader_state_t;

  // Router command encodings: who drives the image RAM port this cycle.
  typedef enum logic [1:0] {
    ROUTER_CMD_IDLE       = 2'd0,
    ROUTER_CMD_UART_WRITE = 2'd1,
    ROUTER_CMD_CPU_READ   = 2'd2,
    ROUTER_CMD_CPU_WRITE  = 2'd3
  } router_cmd_t;

endpackage

`default_nettype wire

// File: rtl/idle_timer.sv
// ============================================================================
//  Module    : idle_timer
//  Purpose   : Saturating idle counter with clear/enable; o_expired is high
//              in the enabled cycle where the count sits at LIMIT-1.
//  Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module idle_timer #(
  parameter int LIMIT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  generate
    if (LIMIT > 0) begin : g_timer
      localparam logic [CW-1:0] C_CNT_MAX = {CW{1'b1}};
      localparam logic [CW-1:0] C_CNT_END = CW'(LIMIT - 1);

      logic [CW-1:0] r_count;

      always_ff @(posedge clk) begin
        if (rst || i_clr) begin
          r_count <= '0;
        end else if (i_en && (r_count != C_CNT_MAX)) begin
          r_count <= r_count + CW'(1);
        end
      end

      assign o_expired = i_en && (r_count == C_CNT_END);
    end else begin : g_no_timer
      logic w_unused;
      assign w_unused  = ^{clk, rst, i_clr, i_en};
      assign o_expired = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/image_rx_loader.sv
// ============================================================================
//  Module    : image_rx_loader
//  Purpose   : Writes UART RX bytes to sequential image RAM addresses and
//              hands the RAM to the CPU once a full image is stored.
//  Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module image_rx_loader
  import image_pkg::*;
#(
  parameter int IMAGE_PIXELS   = IMAGE_PIXELS_DEFAULT,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                  MAIN_CLOCK,
  input  logic                  RESET,
  input  logic [7:0]            RX_DATA,
  input  logic                  RX_DONE,
  input  logic                  CLEAR,
  output logic                  UART_WRITE_EN,
  output logic [ADDR_WIDTH-1:0] UART_ADDRESS,
  output logic [7:0]            DATA_FROM_UART,
  output logic                  START_PROCESSING_FLAG,
  output logic                  RX_OVERRUN,
  output logic                  FRAME_ERROR
);

  // Explicit last address so a full 2^ADDR_WIDTH image returns to 0 by design.
  localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(IMAGE_PIXELS - 1);

  loader_state_t         r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr,  w_addr_next;
  pixel_t                r_data,  w_data_next;
  logic                  r_we,    w_we_next;
  logic                  r_flag,  w_flag_next;
  logic                  r_ovr,   w_ovr_next;
  logic                  r_ferr,  w_ferr_next;
  logic                  w_tmr_en;
  logic                  w_expired;

  assign w_tmr_en = (r_state == LOAD) && (r_addr != '0) && !RX_DONE && !CLEAR;

  idle_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk       (MAIN_CLOCK),
    .rst       (RESET),
    .i_clr     (!w_tmr_en || w_expired),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge MAIN_CLOCK) begin
    if (RESET) begin
      r_state <= LOAD;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_flag  <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_data  <= w_data_next;
      r_we    <= w_we_next;
      r_flag  <= w_flag_next;
      r_ovr   <= w_ovr_next;
      r_ferr  <= w_ferr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_data_next  = r_data;
    w_we_next    = 1'b0;
    w_flag_next  = r_flag;
    w_ovr_next   = r_ovr;
    w_ferr_next  = 1'b0;

    if (CLEAR) begin
      w_state_next = LOAD;
      w_addr_next  = '0;
      w_flag_next  = 1'b0;
      w_ovr_next   = 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (RX_DONE) begin
            w_data_next  = RX_DATA;
            w_we_next    = 1'b1;
            w_state_next = WRITE;
          end else if (w_expired) begin
            w_addr_next = '0;
            w_ferr_next = 1'b1;
          end
        end
        WRITE: begin
          if (RX_DONE) begin
            w_ovr_next = 1'b1;
          end
          if (r_addr == C_LAST_ADDR) begin
            w_addr_next  = '0;
            w_flag_next  = 1'b1;
            w_state_next = FULL;
          end else begin
            w_addr_next  = r_addr + ADDR_WIDTH'(1);
            w_state_next = LOAD;
          end
        end
        FULL: begin
          if (RX_DONE) begin
            w_ovr_next = 1'b1;
          end
        end
        default: w_state_next = LOAD;
      endcase
    end
  end

  assign UART_WRITE_EN         = r_we;
  assign UART_ADDRESS          = r_addr;
  assign DATA_FROM_UART        = r_data;
  assign START_PROCESSING_FLAG = r_flag;
  assign RX_OVERRUN            = r_ovr;
  assign FRAME_ERROR           = r_ferr;

endmodule

`default_nettype wire

// File: tb/tb_image_rx_loader.sv
// ============================================================================
//  Module    : tb_image_rx_loader
//  Purpose   : Directed self-checking bench for image_rx_loader.
//  Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_image_rx_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 4-pixel image, 10-cycle idle timeout
  logic        a_rst, a_rx_done, a_clear;
  logic [7:0]  a_rx_data;
  logic        a_we, a_flag, a_ovr, a_ferr;
  logic [15:0] a_addr;
  logic [7:0]  a_data;

  // DUT B: image fills the whole 4-bit address space, timeout disabled
  logic        b_rst, b_rx_done, b_clear;
  logic [7:0]  b_rx_data;
  logic        b_we, b_flag, b_ovr, b_ferr;
  logic [3:0]  b_addr;
  logic [7:0]  b_data;

  int checks   = 0;
  int failures = 0;

  image_rx_loader #(
    .IMAGE_PIXELS   (4),
    .ADDR_WIDTH     (16),
    .TIMEOUT_CYCLES (10)
  ) dut_a (
    .MAIN_CLOCK            (clk),
    .RESET                 (a_rst),
    .RX_DATA               (a_rx_data),
    .RX_DONE               (a_rx_done),
    .CLEAR                 (a_clear),
    .UART_WRITE_EN         (a_we),
    .UART_ADDRESS          (a_addr),
    .DATA_FROM_UART        (a_data),
    .START_PROCESSING_FLAG (a_flag),
    .RX_OVERRUN            (a_ovr),
    .FRAME_ERROR           (a_ferr)
  );

  image_rx_loader #(
    .IMAGE_PIXELS   (16),
    .ADDR_WIDTH     (4),
    .TIMEOUT_CYCLES (0)
  ) dut_b (
    .MAIN_CLOCK            (clk),
    .RESET                 (b_rst),
    .RX_DATA               (b_rx_data),
    .RX_DONE               (b_rx_done),
    .CLEAR                 (b_clear),
    .UART_WRITE_EN         (b_we),
    .UART_ADDRESS          (b_addr),
    .DATA_FROM_UART        (b_data),
    .START_PROCESSING_FLAG (b_flag),
    .RX_OVERRUN            (b_ovr),
    .FRAME_ERROR           (b_ferr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [7:0] b);
    a_rx_data = b;
    a_rx_done = 1'b1;
    step();
    a_rx_done = 1'b0;
  endtask

  task automatic a_do_clear();
    a_clear = 1'b1;
    step();
    a_clear = 1'b0;
  endtask

  logic [7:0] fill_bytes [4];

  initial begin
    fill_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    a_rst = 1'b1; a_rx_done = 1'b0; a_clear = 1'b0; a_rx_data = 8'h00;
    b_rst = 1'b1; b_rx_done = 1'b0; b_clear = 1'b0; b_rx_data = 8'h00;
    step();
    step();
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Reset state
    chk("rst_we",   a_we,   0);
    chk("rst_addr", a_addr, 0);
    chk("rst_data", a_data, 0);
    chk("rst_flag", a_flag, 0);
    chk("rst_ovr",  a_ovr,  0);
    chk("rst_ferr", a_ferr, 0);
    chk("rst_b_flag", b_flag, 0);

    // Fill four bytes, three cycles apart
    for (int i = 0; i < 4; i++) begin
      a_send(fill_bytes[i]);
      chk("fill_we",   a_we,   1);
      chk("fill_addr", a_addr, i);
      chk("fill_data", a_data, fill_bytes[i]);
      chk("fill_flag_early", a_flag, 0);
      step();
      chk("fill_we_drop", a_we, 0);
      if (i < 3) begin
        chk("fill_addr_inc", a_addr, i + 1);
        chk("fill_flag_low", a_flag, 0);
        step();
      end else begin
        chk("fill_flag_rise", a_flag, 1);
        chk("fill_addr_wrap", a_addr, 0);
      end
    end

    // Overrun when full, then clear
    a_send(8'h55);
    chk("full_no_we", a_we,   0);
    chk("full_ovr",   a_ovr,  1);
    chk("full_flag",  a_flag, 1);
    chk("full_addr",  a_addr, 0);
    step();
    a_do_clear();
    chk("clr_flag", a_flag, 0);
    chk("clr_ovr",  a_ovr,  0);
    chk("clr_addr", a_addr, 0);
    a_send(8'h66);
    chk("post_clr_we",   a_we,   1);
    chk("post_clr_addr", a_addr, 0);
    chk("post_clr_data", a_data, 8'h66);
    step();
    chk("post_clr_inc", a_addr, 1);

    // Back-to-back bytes: second one is dropped
    a_do_clear();
    a_rx_data = 8'hA0;
    a_rx_done = 1'b1;
    step();
    chk("b2b_we",   a_we,   1);
    chk("b2b_data", a_data, 8'hA0);
    chk("b2b_addr", a_addr, 0);
    a_rx_data = 8'hA1;
    step();
    a_rx_done = 1'b0;
    chk("b2b_we_drop", a_we,   0);
    chk("b2b_data2",   a_data, 8'hA0);
    chk("b2b_ovr",     a_ovr,  1);
    chk("b2b_addr2",   a_addr, 1);
    step();
    chk("b2b_no_second_we", a_we, 0);
    chk("b2b_addr3",        a_addr, 1);

    // Idle timeout after two bytes
    a_do_clear();
    a_send(8'h01);
    step();
    step();
    a_send(8'h02);
    step();
    chk("to_addr2", a_addr, 2);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("to_ferr_quiet", a_ferr, 0);
      chk("to_addr_hold",  a_addr, 2);
    end
    step();
    chk("to_ferr_pulse", a_ferr, 1);
    chk("to_addr_reset", a_addr, 0);
    step();
    chk("to_ferr_end", a_ferr, 0);

    // Byte arriving exactly on the expiry cycle wins
    a_do_clear();
    a_send(8'h03);
    step();
    a_send(8'h04);
    step();
    chk("exp_addr2", a_addr, 2);
    for (int i = 0; i < 9; i++) step();
    a_send(8'h77);
    chk("exp_we",   a_we,   1);
    chk("exp_addr", a_addr, 2);
    chk("exp_data", a_data, 8'h77);
    chk("exp_ferr", a_ferr, 0);
    step();
    chk("exp_addr_inc", a_addr, 3);
    chk("exp_ferr2",    a_ferr, 0);

    // CLEAR in the cycle after RX_DONE, with another RX_DONE present
    a_do_clear();
    a_rx_data = 8'h12;
    a_rx_done = 1'b1;
    step();
    chk("midclr_we", a_we, 1);
    a_rx_data = 8'h13;
    a_clear   = 1'b1;
    step();
    a_clear   = 1'b0;
    a_rx_done = 1'b0;
    chk("midclr_we_drop", a_we,   0);
    chk("midclr_addr",    a_addr, 0);
    chk("midclr_ovr",     a_ovr,  0);
    chk("midclr_flag",    a_flag, 0);
    chk("midclr_data",    a_data, 8'h12);
    step();
    chk("midclr_we_once", a_we, 0);

    // RESET in the cycle after RX_DONE
    a_send(8'h34);
    chk("midrst_we", a_we, 1);
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    chk("midrst_we_drop", a_we,   0);
    chk("midrst_addr",    a_addr, 0);
    chk("midrst_data",    a_data, 0);
    a_send(8'h35);
    chk("midrst_load_we",   a_we,   1);
    chk("midrst_load_addr", a_addr, 0);
    chk("midrst_load_data", a_data, 8'h35);

    // Full address-space image on DUT B
    for (int i = 0; i < 16; i++) begin
      b_rx_data = 8'(8'hC0 + i);
      b_rx_done = 1'b1;
      step();
      b_rx_done = 1'b0;
      chk("wrap_we",   b_we,   1);
      chk("wrap_addr", b_addr, i);
      chk("wrap_data", b_data, 8'hC0 + i);
      step();
      if (i < 15) begin
        chk("wrap_inc",  b_addr, i + 1);
        chk("wrap_flag_low", b_flag, 0);
      end else begin
        chk("wrap_flag", b_flag, 1);
        chk("wrap_zero", b_addr, 0);
        chk("wrap_ovr",  b_ovr,  0);
        chk("wrap_ferr", b_ferr, 0);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
